// File: rtl/circle_tracer.sv
// circle_tracer: midpoint-circle point generator with a valid/ready output.
// Each (x,y) step of the midpoint recurrence is emitted as up to eight
// octant-mirrored points around the latched centre (cx,cy).
// Build option: define CIRCLE_TRACER_DEDUP_EN to suppress octant points that
// repeat because they lie on an axis or on a diagonal.
module circle_tracer (
  input  logic               mclock,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] cx,
  input  logic signed [15:0] cy,
  input  logic        [7:0]  r,
  input  logic               out_ready,
  output logic signed [15:0] px,
  output logic signed [15:0] py,
  output logic               pvalid,
  output logic               busy,
  output logic               done
);

`ifdef CIRCLE_TRACER_DEDUP_EN
  localparam bit DEDUP_EN = 1'b1;
`else
  localparam bit DEDUP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  logic signed [15:0] cx_q, cy_q;
  logic signed [15:0] x, y, d;
  logic        [2:0]  k;

  logic signed [15:0] r16;
  logic        [7:0]  emit_mask;
  logic               has_next;
  logic        [2:0]  next_k;
  logic signed [15:0] step_x, step_y, step_d;
  logic               step_done;
  logic        [31:0] pt_start, pt_next, pt_step;

  // Octant mirror of (x,y) for index k, added to the centre with 16-bit wrap.
  function automatic logic [31:0] octant_point(
    input logic signed [15:0] ox,
    input logic signed [15:0] oy,
    input logic signed [15:0] xv,
    input logic signed [15:0] yv,
    input logic        [2:0]  kv
  );
    logic signed [15:0] dx, dy;
    dx = xv;
    dy = yv;
    case (kv)
      3'd0: begin dx =  xv; dy =  yv; end
      3'd1: begin dx =  yv; dy =  xv; end
      3'd2: begin dx = -yv; dy =  xv; end
      3'd3: begin dx = -xv; dy =  yv; end
      3'd4: begin dx = -xv; dy = -yv; end
      3'd5: begin dx = -yv; dy = -xv; end
      3'd6: begin dx =  yv; dy = -xv; end
      default: begin dx = xv; dy = -yv; end
    endcase
    return {16'(ox + dx), 16'(oy + dy)};
  endfunction

  assign r16 = $signed({8'd0, r});

  // Which octant indices are emitted for the current (x,y), and the next one after k.
  always_comb begin
    logic [7:0] m;
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    m         = 8'hFF;
    emit_mask = 8'hFF;
    has_next  = 1'b0;
    next_k    = k;
    if (x == 16'sd0)      m = m & ~8'hE8;  // drop k = 3,5,6,7
    if (x == y)           m = m & ~8'hAA;  // drop k = 1,3,5,7
    if (x == 16'sd0 && y == 16'sd0) m = 8'h01;  // radius 0: only the centre once
    if (DEDUP_EN) emit_mask = m;
    for (int j = 7; j >= 1; j--) begin
      if (j > int'(k) && emit_mask[j]) begin
        has_next = 1'b1;
        next_k   = 3'(j);
      end
    end
  end

  // Midpoint recurrence for the STEP state, from the pre-update x, y and d.
  always_comb begin
    step_x = x + 16'sd1;
    step_y = y;
    step_d = d + (x <<< 1) + 16'sd3;
    if (d >= 16'sd0) begin
      step_d = d + ((x - y) <<< 1) + 16'sd5;
      step_y = y - 16'sd1;
    end
    step_done = (step_x > step_y);
  end

  // Candidate point values for the three ways a new point becomes visible.
  always_comb begin
    pt_start = octant_point(cx, cy, 16'sd0, r16, 3'd0);
    pt_next  = octant_point(cx_q, cy_q, x, y, next_k);
    pt_step  = octant_point(cx_q, cy_q, step_x, step_y, 3'd0);
  end

  // Control FSM with registered point, handshake and status outputs.
  always_ff @(posedge mclock or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cx_q   <= '0;
      cy_q   <= '0;
      x      <= '0;
      y      <= '0;
      d      <= '0;
      k      <= '0;
      px     <= '0;
      py     <= '0;
      pvalid <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            cx_q       <= cx;
            cy_q       <= cy;
            x          <= 16'sd0;
            y          <= r16;
            d          <= 16'sd1 - r16;
            k          <= 3'd0;
            {px, py}   <= pt_start;
            pvalid     <= 1'b1;
            busy       <= 1'b1;
            state      <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (has_next) begin
              k        <= next_k;
              {px, py} <= pt_next;
            end else begin
              pvalid <= 1'b0;
              state  <= STEP;
            end
          end
        end
        STEP: begin
          d <= step_d;
          x <= step_x;
          y <= step_y;
          k <= 3'd0;
          if (step_done) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            {px, py} <= pt_step;
            pvalid   <= 1'b1;
            state    <= EMIT;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_circle_tracer.sv
// Self-checking bench for circle_tracer: a plain-arithmetic point model feeds
// an expected queue, and one compare process checks every transfer, stall and
// done pulse against it.
module tb_circle_tracer;

`ifdef CIRCLE_TRACER_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic               mclock = 1'b0;
  logic               rst;
  logic               start;
  logic signed [15:0] cx, cy;
  logic        [7:0]  r;
  logic               out_ready;
  logic signed [15:0] px, py;
  logic               pvalid, busy, done;

  circle_tracer dut (
    .mclock    (mclock),
    .rst       (rst),
    .start     (start),
    .cx        (cx),
    .cy        (cy),
    .r         (r),
    .out_ready (out_ready),
    .px        (px),
    .py        (py),
    .pvalid    (pvalid),
    .busy      (busy),
    .done      (done)
  );

  always #5 mclock = ~mclock;

  int          vectors     = 0;
  int          miscompares = 0;
  int          xfer_cnt    = 0;
  int          done_cnt    = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mirror (x,y) into octant k around the centre, wrapping to 16 bits.
  function automatic logic [31:0] mirror(input int cxi, input int cyi, input int x, input int y, input int k);
    int ox, oy;
    case (k)
      0: begin ox =  x; oy =  y; end
      1: begin ox =  y; oy =  x; end
      2: begin ox = -y; oy =  x; end
      3: begin ox = -x; oy =  y; end
      4: begin ox = -x; oy = -y; end
      5: begin ox = -y; oy = -x; end
      6: begin ox =  y; oy = -x; end
      default: begin ox = x; oy = -y; end
    endcase
    return {16'(cxi + ox), 16'(cyi + oy)};
  endfunction

  function automatic bit kept(input int x, input int y, input int k);
    bit on_axis, on_diag, origin;
    on_axis = (x == 0) && (k == 3 || k == 5 || k == 6 || k == 7);
    on_diag = (x == y) && (k == 1 || k == 3 || k == 5 || k == 7);
    origin  = (x == 0) && (y == 0) && (k != 0);
    return !DEDUP || !(on_axis || on_diag || origin);
  endfunction

  // Expected point list for one trace: midpoint circle, eight mirrors per step.
  task automatic build_model(input int cxi, input int cyi, input int ri);
    int x, y, d;
    x = 0; y = ri; d = 1 - ri;
    do begin
      for (int k = 0; k < 8; k++)
        if (kept(x, y, k)) exp_q.push_back(mirror(cxi, cyi, x, y, k));
      if (d < 0) d = d + 2 * x + 3;
      else begin
        d = d + 2 * (x - y) + 5;
        y = y - 1;
      end
      x = x + 1;
    end while (x <= y);
  endtask

  // Compare process: transfers, stall stability and done pulses.
  logic        prev_stall = 1'b0;
  logic        prev_done  = 1'b0;
  logic [31:0] prev_pt    = '0;
  always @(negedge mclock) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_pvalid", 32'(pvalid), 32'd1);
        check("stall_pxpy", {px, py}, prev_pt);
      end
      if (pvalid && out_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_point: got %h, expected no transfer (t=%0t)", {px, py}, $time);
        end else begin
          check("point", {px, py}, exp_q.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        check("done_width", 32'(prev_done), 32'd0);
        check("done_busy", 32'(busy), 32'd1);
        check("done_after_last", 32'(exp_q.size()), 32'd0);
      end
      prev_stall = pvalid && !out_ready;
      prev_pt    = {px, py};
      prev_done  = done;
    end
  end

  task automatic run_trace(input int cxi, input int cyi, input int ri,
                           input bit rand_ready, input bit poke_start);
    int exp_n, x0, d0, cyc;
    exp_q.delete();
    build_model(cxi, cyi, ri);
    exp_n = exp_q.size();
    x0    = xfer_cnt;
    d0    = done_cnt;
    @(posedge mclock); #1;
    cx        = 16'(cxi);
    cy        = 16'(cyi);
    r         = 8'(ri);
    start     = 1'b1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge mclock); #1;
    start = 1'b0;
    check("pvalid_after_start", 32'(pvalid), 32'd1);
    check("busy_after_start", 32'(busy), 32'd1);
    check("first_point", {px, py}, exp_q[0]);
    cyc = 0;
    while (done_cnt == d0 && cyc < 20000) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke_start && cyc == 3) begin
        start = 1'b1;
        r     = 8'd9;
        cx    = 16'sd123;
      end else begin
        start = 1'b0;
      end
      @(posedge mclock); #1;
      cyc++;
    end
    start = 1'b0;
    check("trace_done", 32'(done_cnt - d0), 32'd1);
    check("point_total", 32'(xfer_cnt - x0), 32'(exp_n));
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_pvalid", 32'(pvalid), 32'd0);
  endtask

  logic [31:0] r1_full [8];
  logic [31:0] r1_dedup[4];
  int          d0;

  initial begin
    r1_full  = '{32'h0000_0001, 32'h0001_0000, 32'hFFFF_0000, 32'h0000_0001,
                 32'h0000_FFFF, 32'hFFFF_0000, 32'h0001_0000, 32'h0000_FFFF};
    r1_dedup = '{32'h0000_0001, 32'h0001_0000, 32'hFFFF_0000, 32'h0000_FFFF};

    rst = 1'b1; start = 1'b0; cx = '0; cy = '0; r = '0; out_ready = 1'b0;
    #12;
    check("rst_pvalid", 32'(pvalid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pxpy", {px, py}, 32'h0);
    #5 rst = 1'b0;

    // Pin the model to hand-computed point lists.
    exp_q.delete();
    build_model(0, 0, 1);
    check("model_r1_size", 32'(exp_q.size()), DEDUP ? 32'd4 : 32'd8);
    for (int i = 0; i < exp_q.size() && i < 8; i++)
      check("model_r1_point", exp_q[i], DEDUP ? r1_dedup[i % 4] : r1_full[i]);
    exp_q.delete();
    build_model(10, -5, 2);
    check("model_r2_size", 32'(exp_q.size()), DEDUP ? 32'd12 : 32'd16);
    check("model_r2_first_of_group2", exp_q[DEDUP ? 4 : 8], 32'h000B_FFFD);
    exp_q.delete();
    build_model(3, 4, 0);
    check("model_r0_size", 32'(exp_q.size()), DEDUP ? 32'd1 : 32'd8);
    for (int i = 0; i < exp_q.size(); i++)
      check("model_r0_point", exp_q[i], 32'h0003_0004);
    exp_q.delete();

    run_trace(0, 0, 1, 1'b0, 1'b0);
    run_trace(10, -5, 2, 1'b0, 1'b0);
    run_trace(3, 4, 0, 1'b0, 1'b0);
    run_trace(100, -200, 5, 1'b0, 1'b0);
    run_trace(100, -200, 5, 1'b1, 1'b0);
    run_trace(-7, 9, 5, 1'b0, 1'b1);
    run_trace(32767, -32768, 3, 1'b0, 1'b0);
    run_trace(-1000, 500, 255, 1'b1, 1'b0);

    // Reset in the middle of a stalled EMIT.
    exp_q.delete();
    d0 = done_cnt;
    @(posedge mclock); #1;
    cx = 16'sd50; cy = 16'sd60; r = 8'd5; start = 1'b1; out_ready = 1'b0;
    @(posedge mclock); #1;
    start = 1'b0;
    repeat (3) @(posedge mclock);
    #3;
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_pvalid", 32'(pvalid), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_pvalid", 32'(pvalid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_pxpy", {px, py}, 32'h0);
    #20;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge mclock);
    #1;
    check("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
    check("idle_after_rst", 32'(busy), 32'd0);

    run_trace(1, 2, 4, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/circle_tracer.md
CIRCLE_TRACER -- requirements
Module: circle_tracer

Interface
REQ-001 SHALL have port mclock, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: requests a trace; sampled only in IDLE.
REQ-004 SHALL have ports cx and cy, input, signed 16 bits each: the circle centre, latched when start is accepted.
REQ-005 SHALL have port r, input, unsigned 8 bits: the radius, 0..255, latched when start is accepted.
REQ-006 SHALL have port out_ready, input, 1 bit: the consumer is ready to take a point.
REQ-007 SHALL have ports px and py, output, signed 16 bits each: the current point's coordinates.
REQ-008 SHALL have port pvalid, output, 1 bit: px/py hold a valid point.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when a trace finishes.

Function
REQ-011 SHALL implement the FSM states IDLE, EMIT, STEP and DONE.
REQ-012 SHALL, in IDLE with start=1 at a clock edge, load x=0, y=r, d=1-r (signed 16-bit), k=0, latch cx, cy and r, and go to EMIT; pvalid SHALL therefore be high in the cycle after start.
REQ-013 SHALL ignore start in every state other than IDLE.
REQ-014 SHALL, in EMIT, drive pvalid=1 and px/py = (cx,cy) plus the octant-k offset, where k=0..7 gives (+x,+y), (+y,+x), (-y,+x), (-x,+y), (-x,-y), (-y,-x), (+y,-x), (+x,-y).
REQ-015 SHALL transfer a point only on a cycle where pvalid=1 and out_ready=1; px, py and pvalid SHALL stay stable until that transfer.
REQ-016 SHALL, on a transfer in EMIT, increment k, or go to STEP if the point was the last one emitted for the current (x,y).
REQ-017 SHALL hold pvalid=0 for exactly one cycle in STEP.
REQ-018 SHALL, in STEP when d<0, set d=d+2x+3; otherwise it SHALL set d=d+2(x-y)+5 and y=y-1, using the pre-update x and y in both cases.
REQ-019 SHALL, in STEP, set x=x+1 and k=0, then go to DONE if new x > new y, otherwise to EMIT.
REQ-020 SHALL compute px/py additions in 16-bit two's complement, wrapping on overflow with no saturation.
REQ-021 SHALL, in DONE, assert done=1 and busy=1 for one cycle, then go to IDLE.
REQ-022 SHALL handle r=0 as one (x,y) group at (0,0), followed by DONE.
REQ-023 SHALL, if out_ready is low indefinitely, hold the FSM in EMIT with no loss of data.

Reset
REQ-024 SHALL, while rst=1 and regardless of mclock, force state=IDLE, pvalid=0, busy=0, done=0, px=0, py=0, x=y=d=k=0.
REQ-025 SHALL, if rst is asserted mid-trace, abandon the trace; after release the FSM SHALL wait in IDLE for a new start and SHALL NOT produce a done pulse for the abandoned trace.

Configuration
REQ-026 SHALL provide the macro CIRCLE_TRACER_DEDUP_EN; when it is undefined, all 8 octant points SHALL be emitted for every (x,y), duplicates included.
REQ-027 SHALL, when CIRCLE_TRACER_DEDUP_EN is defined, skip k in {3,5,6,7} when x==0 and skip k in {1,3,5,7} when x==y, skipping the union when both hold; skipped k SHALL take no cycle and produce no transfer.

Verification
REQ-028 SHALL cover: r=1, c=(0,0), out_ready=1 -> 8 points (0,1),(1,0),(-1,0),(0,1),(0,-1),(-1,0),(1,0),(0,-1), then one done pulse; with DEDUP_EN -> 4 points (0,1),(1,0),(-1,0),(0,-1).
REQ-029 SHALL cover: r=2, c=(10,-5), out_ready=1 -> 16 points, the 9th being (11,-3); with DEDUP_EN -> 12 points.
REQ-030 SHALL cover: r=0 -> 8 copies of (cx,cy) without DEDUP_EN, and 1 with it; done SHALL follow the last point.
REQ-031 SHALL cover: out_ready toggled randomly during r=5 -> point sequence identical to the out_ready=1 run, with px/py/pvalid stable during every stall.
REQ-032 SHALL cover: start pulsed while busy -> ignored, point count unchanged.
REQ-033 SHALL cover: rst asserted mid-EMIT -> pvalid and busy fall with no clock edge; no done pulse; a new start afterwards traces normally.
